serv_wb2axi_bridge: RTL and testbench

Single-outstanding bridge from the SERV data-bus (Wishbone-classic style: `cyc`/`we`/`sel`/`adr`/`dat` → `rdt`/`ack`) to an AXI4 master port. It sits directly downstream of `serv_rf_top`'s `o_dbus_*` / `i_dbus_*` pins and replaces the behavioural memory model with a real AXI4 interconnect master. Each bus cycle becomes exactly one single-beat 32-bit AXI transaction.

---
 rtl/serv_axi_pkg.sv | 28 ++
 rtl/serv_wb2axi_bridge.sv | 180 ++++++++++++++++++
 tb/tb_serv_wb2axi_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serv_axi_pkg.sv
// Shared AXI4 encodings and the FSM state type for the SERV Wishbone-to-AXI bridge.
package serv_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_ACK
    } wb2axi_state_e;

endpackage

// File: rtl/serv_wb2axi_bridge.sv
// SERV data bus to single-beat AXI4 master bridge; one transaction in flight at a time.
// Define SERV_WB2AXI_ERR_EN to capture non-OKAY responses into sticky o_err / o_err_adr.
module serv_wb2axi_bridge
    import serv_axi_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic [31:0]       i_wb_adr,
    input  logic [31:0]       i_wb_dat,
    input  logic [3:0]        i_wb_sel,
    input  logic              i_wb_we,
    input  logic              i_wb_cyc,
    output logic [31:0]       o_wb_rdt,
    output logic              o_wb_ack,
    output logic [ID_W-1:0]   m_axi_awid,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [ID_W-1:0]   m_axi_bid,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ID_W-1:0]   m_axi_arid,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [ID_W-1:0]   m_axi_rid,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic              o_err,
    output logic [31:0]       o_err_adr
);

    wb2axi_state_e     state;
    logic              aw_done, w_done;
    logic              aw_hs, w_hs, ar_hs;
    logic [ADDR_W-1:0] axi_adr;

    assign aw_hs   = m_axi_awvalid & m_axi_awready;
    assign w_hs    = m_axi_wvalid & m_axi_wready;
    assign ar_hs   = m_axi_arvalid & m_axi_arready;
    assign axi_adr = ADDR_W'({i_wb_adr[31:2], 2'b00});

    assign m_axi_awid    = '0;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = AXI_SIZE_4B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_arid    = '0;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = AXI_SIZE_4B;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arprot  = 3'b000;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= S_IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_araddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_rready  <= 1'b0;
            o_wb_ack      <= 1'b0;
            o_wb_rdt      <= '0;
        end else begin
            o_wb_ack <= 1'b0;
            case (state)
                S_IDLE: if (i_wb_cyc) begin
                    if (i_wb_we) begin
                        m_axi_awaddr  <= axi_adr;
                        m_axi_wdata   <= i_wb_dat;
                        m_axi_wstrb   <= i_wb_sel;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        state         <= S_WR_ADDR_DATA;
                    end else begin
                        m_axi_araddr  <= axi_adr;
                        m_axi_arvalid <= 1'b1;
                        state         <= S_RD_ADDR;
                    end
                end
                // AW and W retire independently; leave once both have handshaken.
                S_WR_ADDR_DATA: begin
                    if (aw_hs) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        m_axi_bready <= 1'b1;
                        state        <= S_WR_RESP;
                    end
                end
                S_WR_RESP: if (m_axi_bvalid) begin
                    m_axi_bready <= 1'b0;
                    o_wb_ack     <= 1'b1;
                    state        <= S_ACK;
                end
                S_RD_ADDR: if (ar_hs) begin
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b1;
                    state         <= S_RD_DATA;
                end
                S_RD_DATA: if (m_axi_rvalid) begin
                    m_axi_rready <= 1'b0;
                    o_wb_rdt     <= m_axi_rdata;
                    o_wb_ack     <= 1'b1;
                    state        <= S_ACK;
                end
                S_ACK: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SERV_WB2AXI_ERR_EN
    logic [31:0] adr_q;
    logic        resp_err;
    logic        unused_ok;

    // bready/rready are high exactly in WR_RESP/RD_DATA, so valid there means handshake.
    assign resp_err = (state == S_WR_RESP && m_axi_bvalid && m_axi_bresp != RESP_OKAY) ||
                      (state == S_RD_DATA && m_axi_rvalid && m_axi_rresp != RESP_OKAY);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            adr_q     <= '0;
            o_err     <= 1'b0;
            o_err_adr <= '0;
        end else begin
            if (state == S_IDLE && i_wb_cyc)
                adr_q <= i_wb_adr;
            if (resp_err && !o_err) begin
                o_err     <= 1'b1;
                o_err_adr <= adr_q;
            end
        end
    end

    assign unused_ok = ^{m_axi_bid, m_axi_rid, m_axi_rlast};
`else
    logic unused_ok;

    assign o_err     = 1'b0;
    assign o_err_adr = '0;
    assign unused_ok = ^{m_axi_bid, m_axi_rid, m_axi_rlast, m_axi_bresp, m_axi_rresp, i_wb_adr[1:0]};
`endif

endmodule

// File: tb/tb_serv_wb2axi_bridge.sv
// Bench for serv_wb2axi_bridge: SERV-side driver, stall-configurable AXI slave RAM and a word-array scoreboard.
`timescale 1ns/1ps
module tb_serv_wb2axi_bridge;
    import serv_axi_pkg::*;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] i_wb_adr, i_wb_dat, o_wb_rdt, o_err_adr;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we, i_wb_cyc, o_wb_ack, o_err;
    logic [ID_W-1:0]   m_axi_awid, m_axi_bid, m_axi_arid, m_axi_rid;
    logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;

    serv_wb2axi_bridge #(.ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .i_rst(rst),
        .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we),
        .i_wb_cyc(i_wb_cyc), .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .o_err(o_err), .o_err_adr(o_err_adr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Slave configuration: cycles of valid seen with ready held low, and response delays.
    int aw_stall = 0, w_stall = 0, b_stall = 0, ar_stall = 0, r_stall = 0;
    logic [1:0]  cfg_resp = 2'b00;
    bit          force_rdata = 0;
    logic [31:0] force_val = '0;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    bit aw_have, w_have, ar_have, hs_aw, hs_w, hs_b, hs_ar, hs_r;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [31:0] lat_awaddr, lat_wdata, lat_araddr;
    logic [3:0]  lat_wstrb;
    int awv_cyc = 0, wv_cyc = 0, ack_total = 0;

    // AXI slave RAM; everything changes on negedge, handshakes are the posedge in between.
    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = '0;
        m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rid = '0; m_axi_rlast = 0; m_axi_rdata = '0;
        forever begin
            @(negedge clk);
            if (o_wb_ack) ack_total++;
            if (rst) begin
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_rvalid = 0;
                aw_have = 0; w_have = 0; ar_have = 0;
                hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                continue;
            end
            if (m_axi_awvalid) awv_cyc++;
            if (m_axi_wvalid) wv_cyc++;
            if (hs_aw) aw_have = 1;
            if (hs_w) w_have = 1;
            if (hs_b) begin m_axi_bvalid = 0; aw_have = 0; w_have = 0; end
            if (hs_ar) ar_have = 1;
            if (hs_r) begin m_axi_rvalid = 0; ar_have = 0; end

            if (m_axi_awvalid && !aw_have) begin
                if (aw_cnt >= aw_stall) begin m_axi_awready = 1; lat_awaddr = m_axi_awaddr; end
                else begin m_axi_awready = 0; aw_cnt++; end
            end else begin m_axi_awready = 0; aw_cnt = 0; end

            if (m_axi_wvalid && !w_have) begin
                if (w_cnt >= w_stall) begin
                    m_axi_wready = 1; lat_wdata = m_axi_wdata; lat_wstrb = m_axi_wstrb;
                end else begin m_axi_wready = 0; w_cnt++; end
            end else begin m_axi_wready = 0; w_cnt = 0; end

            if (m_axi_arvalid && !ar_have) begin
                if (ar_cnt >= ar_stall) begin m_axi_arready = 1; lat_araddr = m_axi_araddr; end
                else begin m_axi_arready = 0; ar_cnt++; end
            end else begin m_axi_arready = 0; ar_cnt = 0; end

            if (aw_have && w_have && !m_axi_bvalid) begin
                if (b_cnt >= b_stall) begin
                    for (int i = 0; i < 4; i++)
                        if (lat_wstrb[i]) mem[lat_awaddr[11:2]][8*i +: 8] = lat_wdata[8*i +: 8];
                    m_axi_bvalid = 1; m_axi_bresp = cfg_resp; b_cnt = 0;
                end else b_cnt++;
            end

            if (ar_have && !m_axi_rvalid) begin
                if (r_cnt >= r_stall) begin
                    m_axi_rdata = force_rdata ? force_val : mem[lat_araddr[11:2]];
                    m_axi_rvalid = 1; m_axi_rresp = cfg_resp; m_axi_rlast = 1; r_cnt = 0;
                end else r_cnt++;
            end

            hs_aw = m_axi_awvalid && m_axi_awready;
            hs_w  = m_axi_wvalid && m_axi_wready;
            hs_ar = m_axi_arvalid && m_axi_arready;
            hs_b  = m_axi_bvalid && m_axi_bready;
            hs_r  = m_axi_rvalid && m_axi_rready;
        end
    end

    // One SERV bus cycle; lat counts negedges from request to the one where ack is seen.
    task automatic wb_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rdt, output int lat,
                          output int bready_low);
        i_wb_cyc = 1; i_wb_we = we; i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel;
        lat = 0; bready_low = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (o_wb_ack) break;
            if (lat >= 2 && m_axi_bready !== 1'b1) bready_low++;
            if (lat > 200) break;
        end
        rdt = o_wb_rdt;
        i_wb_cyc = 0; i_wb_we = 0;
    endtask

    task automatic test_reset();
        rst = 1; i_wb_cyc = 0; i_wb_we = 0; i_wb_adr = '0; i_wb_dat = '0; i_wb_sel = '0;
        repeat (2) @(negedge clk);
        tests++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, o_wb_ack} !== 6'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 000000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, o_wb_ack});
        end
        tests++;
        if ({o_wb_rdt, o_err, o_err_adr} !== 65'b0) begin
            fails++; $display("FAIL reset_data: rdt=%h err=%b err_adr=%h want all 0", o_wb_rdt, o_err, o_err_adr);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_read_min_latency();
        logic [31:0] rdt; int lat, bl, a0;
        mem[32'h100 >> 2] = 32'hDEADBEEF; ref_mem[32'h100 >> 2] = 32'hDEADBEEF;
        a0 = ack_total;
        wb_txn(0, 32'h102, '0, 4'hf, rdt, lat, bl);
        tests++;
        if (lat_araddr !== 32'h100) begin fails++; $display("FAIL rd_araddr: got %h want 00000100", lat_araddr); end
        tests++;
        if (rdt !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got %h want deadbeef", rdt); end
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL rd_latency: got %0d want 3", lat); end
        tests++;
        if ({m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arprot} !== {8'd0, 3'b010, 2'b01, 3'b000}) begin
            fails++; $display("FAIL ar_fields: len=%h size=%b burst=%b prot=%b", m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arprot);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (ack_total - a0 !== 1) begin fails++; $display("FAIL rd_ack_count: got %0d want 1", ack_total - a0); end
    endtask

    task automatic test_write_aw_stall();
        logic [31:0] rdt; int lat, bl, a0;
        aw_stall = 2; awv_cyc = 0; wv_cyc = 0; a0 = ack_total;
        wb_txn(1, 32'h200, 32'h11223344, 4'b0100, rdt, lat, bl);
        ref_mem[32'h200 >> 2][23:16] = 8'h22;
        aw_stall = 0;
        tests++;
        if (awv_cyc !== 3 || wv_cyc !== 1) begin
            fails++; $display("FAIL wr_valid_cycles: aw=%0d w=%0d want aw=3 w=1", awv_cyc, wv_cyc);
        end
        tests++;
        if (lat_wstrb !== 4'b0100 || lat_awaddr !== 32'h200 || lat_wdata !== 32'h11223344) begin
            fails++; $display("FAIL wr_payload: strb=%b addr=%h data=%h", lat_wstrb, lat_awaddr, lat_wdata);
        end
        tests++;
        if (lat !== 5) begin fails++; $display("FAIL wr_latency: got %0d want 5", lat); end
        tests++;
        if ({m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wlast} !== {8'd0, 3'b010, 2'b01, 1'b1}) begin
            fails++; $display("FAIL aw_fields: len=%h size=%b burst=%b wlast=%b", m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wlast);
        end
        tests++;
        if (mem[32'h200 >> 2] !== ref_mem[32'h200 >> 2]) begin
            fails++; $display("FAIL wr_merge: got %h want %h", mem[32'h200 >> 2], ref_mem[32'h200 >> 2]);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (ack_total - a0 !== 1) begin fails++; $display("FAIL wr_ack_count: got %0d want 1", ack_total - a0); end
    endtask

    task automatic test_b_wait();
        logic [31:0] rdt; int lat, bl;
        b_stall = 10;
        wb_txn(1, 32'h204, 32'hA5A5A5A5, 4'b1111, rdt, lat, bl);
        ref_mem[32'h204 >> 2] = 32'hA5A5A5A5;
        b_stall = 0;
        tests++;
        if (bl !== 0) begin fails++; $display("FAIL bwait_bready: low for %0d cycles want 0", bl); end
        tests++;
        if (lat !== 13) begin fails++; $display("FAIL bwait_latency: got %0d want 13", lat); end
        @(negedge clk);
    endtask

    task automatic test_err_resp();
        logic [31:0] rdt; int lat, bl;
        logic exp_err; logic [31:0] exp_adr;
`ifdef SERV_WB2AXI_ERR_EN
        exp_err = 1; exp_adr = 32'h300;
`else
        exp_err = 0; exp_adr = 32'h0;
`endif
        cfg_resp = RESP_SLVERR; force_rdata = 1; force_val = 32'hCAFE0000;
        wb_txn(0, 32'h300, '0, 4'hf, rdt, lat, bl);
        cfg_resp = RESP_OKAY; force_rdata = 0;
        tests++;
        if (rdt !== 32'hCAFE0000 || lat !== 3) begin
            fails++; $display("FAIL err_rdata: rdt=%h lat=%0d want cafe0000 lat=3", rdt, lat);
        end
        @(negedge clk);
        tests++;
        if (o_err !== exp_err || o_err_adr !== exp_adr) begin
            fails++; $display("FAIL err_flag: err=%b adr=%h want err=%b adr=%h", o_err, o_err_adr, exp_err, exp_adr);
        end
    endtask

    task automatic test_reset_mid_txn();
        logic [31:0] rdt; int lat, bl, n;
        b_stall = 50; n = 0;
        i_wb_cyc = 1; i_wb_we = 1; i_wb_adr = 32'h208; i_wb_dat = 32'h01020304; i_wb_sel = 4'hf;
        do begin @(negedge clk); n++; end while (m_axi_bready !== 1'b1 && n < 20);
        tests++;
        if (m_axi_bready !== 1'b1) begin fails++; $display("FAIL rst_reach_wresp: bready=%b want 1", m_axi_bready); end
        rst = 1;
        #1;
        tests++;
        if ({m_axi_bready, o_wb_ack, m_axi_awvalid, m_axi_wvalid} !== 4'b0) begin
            fails++; $display("FAIL rst_mid_outputs: bready=%b ack=%b awv=%b wv=%b want 0",
                m_axi_bready, o_wb_ack, m_axi_awvalid, m_axi_wvalid);
        end
        i_wb_cyc = 0; i_wb_we = 0; b_stall = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        tests++;
        if (o_err !== 1'b0) begin fails++; $display("FAIL rst_err_clear: got %b want 0", o_err); end
        wb_txn(0, 32'h0, '0, 4'hf, rdt, lat, bl);
        tests++;
        if (rdt !== ref_mem[0] || lat !== 3) begin
            fails++; $display("FAIL rst_recover_read: rdt=%h lat=%0d want %h lat=3", rdt, lat, ref_mem[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rdt, adr, dat; logic [3:0] sel; int lat, bl, a0, idx, errs; bit we;
        a0 = ack_total; errs = 0;
        for (int t = 0; t < 100; t++) begin
            aw_stall = $urandom_range(0, 3); w_stall = $urandom_range(0, 3);
            b_stall = $urandom_range(0, 3); ar_stall = $urandom_range(0, 3);
            r_stall = $urandom_range(0, 3);
            idx = 32'h200 + $urandom_range(0, 15);
            adr = (idx << 2) | $urandom_range(0, 3);
            we = $urandom_range(0, 1);
            dat = $urandom; sel = $urandom_range(0, 15);
            wb_txn(we, adr, dat, sel, rdt, lat, bl);
            tests++;
            if (lat > 200) begin
                fails++; $display("FAIL b2b_timeout: txn %0d no ack within 200 cycles", t);
                break;
            end
            if (we) begin
                for (int i = 0; i < 4; i++)
                    if (sel[i]) ref_mem[idx][8*i +: 8] = dat[8*i +: 8];
            end else if (rdt !== ref_mem[idx]) begin
                fails++; errs++;
                if (errs < 5) $display("FAIL b2b_read: txn %0d adr=%h got %h want %h", t, adr, rdt, ref_mem[idx]);
            end
        end
        aw_stall = 0; w_stall = 0; b_stall = 0; ar_stall = 0; r_stall = 0;
        repeat (3) @(negedge clk);
        tests++;
        if (ack_total - a0 !== 100) begin fails++; $display("FAIL b2b_ack_count: got %0d want 100", ack_total - a0); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        mem[0] = 32'h5A5A0001; ref_mem[0] = 32'h5A5A0001;
        test_reset();
        test_read_min_latency();
        test_write_aw_stall();
        test_b_wait();
        test_err_resp();
        test_reset_mid_txn();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
